// File: rtl/sensor_input_filter.sv
// Six-line sensor front end: 2-FF synchroniser, per-channel debounce, change strobe
// and water-probe plausibility fault. Define SENSOR_FAULT_LATCH_EN for a sticky fault.
module sensor_input_filter #(
   parameter int unsigned CHANNELS      = 6,
   parameter int unsigned STABLE_CYCLES = 1000,
   parameter int unsigned CNT_W         = 10
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_sensors,
   input  logic                fault_clear,
   output logic [CHANNELS-1:0] filtered_sensors,
   output logic                change_strobe,
   output logic                sensor_fault
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [CHANNELS-1:0] s1;
   logic [CHANNELS-1:0] s2;
   logic [CHANNELS-1:0] filt_next;
   logic [CNT_W-1:0]    cnt      [CHANNELS];
   logic [CNT_W-1:0]    cnt_next [CHANNELS];
   logic [2:0]          water;
   logic                invalid;
   logic                fault_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw_sensors;
         s2 <= s1;
      end
   end

   // Any agreement between s2 and the filtered level restarts that channel's window.
   always_comb begin
      filt_next = filtered_sensors;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cnt_next[i] = '0;
         if (s2[i] != filtered_sensors[i]) begin
            if (cnt[i] == CNT_LAST) begin
               filt_next[i] = s2[i];
            end else begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         filtered_sensors <= '0;
         change_strobe    <= 1'b0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         filtered_sensors <= filt_next;
         change_strobe    <= |(filt_next ^ filtered_sensors);
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   assign water   = filtered_sensors[2:0];
   assign invalid = (water[2] & ~water[1]) | (water[1] & ~water[0]) | (water[2] & ~water[0]);

`ifdef SENSOR_FAULT_LATCH_EN
   always_comb begin
      fault_next = sensor_fault;
      if (invalid) begin
         fault_next = 1'b1;
      end else if (fault_clear) begin
         fault_next = 1'b0;
      end
   end
`else
   logic unused_fault_clear;
   assign unused_fault_clear = fault_clear;

   always_comb begin
      fault_next = invalid;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         sensor_fault <= 1'b0;
      end else begin
         sensor_fault <= fault_next;
      end
   end

endmodule
